stripe_scroller: RTL and testbench

Parametrised animated-stripe pattern generator for the TinyVGA demo designs. It sits between `hvsync_generator` and the TinyVGA PMOD output mapping. It consumes beam position and sync, and produces 2-bit R/G/B plus sync delayed one cycle to stay aligned. Direction, speed, pause, colour inversion and stripe scale come from a mode byte, normally `ui_in`, sampled once per frame so the picture never tears mid-frame.

---
 rtl/stripe_scroller.sv | 97 +++++++++
 tb/tb_stripe_scroller.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/stripe_scroller.sv
// rtl/stripe_scroller.sv - animated stripe pattern generator between hvsync_generator and the TinyVGA PMOD
// Mode byte is latched once per frame on the vpos wrap so the picture never tears mid-frame.
module stripe_scroller #(
    parameter int PIX_W       = 10,
    parameter int OFFSET_W    = 10,
    parameter int STRIPE_LOG2 = 3,
    parameter int FRAME_W     = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               hsync_in,
    input  logic               vsync_in,
    input  logic               display_on,
    input  logic [PIX_W-1:0]   hpos,
    input  logic [PIX_W-1:0]   vpos,
    input  logic [7:0]         mode,
    output logic               hsync_out,
    output logic               vsync_out,
    output logic [1:0]         r,
    output logic [1:0]         g,
    output logic [1:0]         b,
    output logic [FRAME_W-1:0] frame_count
);

    logic [PIX_W-1:0]    prev_vpos_q;
    logic [OFFSET_W-1:0] offset_q, offset_d;
    logic [7:0]          mode_q, mode_d;
    logic [FRAME_W-1:0]  frame_q, frame_d;
    logic [5:0]          rgb_q, rgb_d;
    logic                hsync_q, vsync_q;

    logic                tick;
    logic [OFFSET_W-1:0] base, u;
    logic [7:0]          shift;
    logic [2:0]          ubits;
    logic                w2, w5;

    // Speed and pause bits are consumed live at the tick, so their latched copies go unused.
    logic unused_mode_bits;
    assign unused_mode_bits = ^mode_q[4:2];

    always_comb begin
        tick     = (vpos == '0) && (prev_vpos_q != '0);
        mode_d   = mode_q;
        frame_d  = frame_q;
        offset_d = offset_q;
        if (tick) begin
            mode_d  = mode;
            frame_d = frame_q + FRAME_W'(1);
            if (!mode[4]) begin
                offset_d = offset_q + (OFFSET_W'(1) << mode[3:2]);
            end
        end
    end

    // Colour uses the registered offset/mode, so the tick pixel still sees pre-update values.
    always_comb begin
        base  = mode_q[1] ? OFFSET_W'(vpos) : OFFSET_W'(hpos);
        w2    = mode_q[1] ? hpos[2] : vpos[2];
        w5    = mode_q[1] ? hpos[5] : vpos[5];
        u     = mode_q[0] ? (base - offset_q) : (base + offset_q);
        shift = 8'(STRIPE_LOG2) + {6'b0, mode_q[7:6]};
        ubits = 3'(u >> shift);
        rgb_d = '0;
        if (display_on) begin
            rgb_d = {ubits[0], w2, ubits[1], w2, ubits[2], w5} ^ {6{mode_q[5]}};
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            prev_vpos_q <= '0;
            offset_q    <= '0;
            mode_q      <= '0;
            frame_q     <= '0;
            rgb_q       <= '0;
            hsync_q     <= 1'b1;
            vsync_q     <= 1'b1;
        end else begin
            prev_vpos_q <= vpos;
            offset_q    <= offset_d;
            mode_q      <= mode_d;
            frame_q     <= frame_d;
            rgb_q       <= rgb_d;
            hsync_q     <= hsync_in;
            vsync_q     <= vsync_in;
        end
    end

    assign hsync_out   = hsync_q;
    assign vsync_out   = vsync_q;
    assign r           = rgb_q[5:4];
    assign g           = rgb_q[3:2];
    assign b           = rgb_q[1:0];
    assign frame_count = frame_q;

endmodule

// File: tb/tb_stripe_scroller.sv
// tb/tb_stripe_scroller.sv - directed self-checking bench for stripe_scroller
// Frames are shortened to a few beam positions; a tick is vpos returning to 0.
module tb_stripe_scroller;

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic       hsync_in = 1'b1, vsync_in = 1'b1, display_on = 1'b0;
    logic [9:0] hpos = '0, vpos = '0;
    logic [7:0] mode = '0;
    logic       hsync_out, vsync_out;
    logic [1:0] r, g, b;
    logic [7:0] frame_count;
    int         total = 0;
    int         bad = 0;

    stripe_scroller dut (
        .clk(clk), .rst_n(rst_n), .hsync_in(hsync_in), .vsync_in(vsync_in),
        .display_on(display_on), .hpos(hpos), .vpos(vpos), .mode(mode),
        .hsync_out(hsync_out), .vsync_out(vsync_out), .r(r), .g(g), .b(b),
        .frame_count(frame_count)
    );

    always #5 clk = ~clk;

    task automatic step(input int h, input int v, input logic de, input logic hs, input logic vs);
        hpos       = 10'(h);
        vpos       = 10'(v);
        display_on = de;
        hsync_in   = hs;
        vsync_in   = vs;
        @(posedge clk);
        #1;
    endtask

    task automatic new_frame();
        step(0, 1, 1'b0, 1'b1, 1'b1);
        step(0, 0, 1'b0, 1'b1, 1'b1);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        step(0, 0, 1'b0, 1'b1, 1'b1);
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        new_frame();
        rst_n = 1'b0;
        step(7, 7, 1'b1, 1'b0, 1'b0);
        rst_n = 1'b1;
        total++; if ({r, g, b} !== 6'b0) begin bad++; $display("FAIL reset_rgb act=%b exp=%b", {r, g, b}, 6'b0); end
        total++; if ({hsync_out, vsync_out} !== 2'b11) begin bad++; $display("FAIL reset_sync act=%b exp=%b", {hsync_out, vsync_out}, 2'b11); end
        total++; if (frame_count !== 8'd0) begin bad++; $display("FAIL reset_frame act=%0d exp=0", frame_count); end
        total++; if (dut.offset_q !== 10'd0) begin bad++; $display("FAIL reset_offset act=%0d exp=0", dut.offset_q); end
    endtask

    task automatic test_two_frames();
        do_reset();
        mode = 8'h00;
        step(0, 0, 1'b0, 1'b1, 1'b1);
        total++; if (frame_count !== 8'd0) begin bad++; $display("FAIL first_frame_no_tick act=%0d exp=0", frame_count); end
        step(5, 3, 1'b0, 1'b1, 1'b1);
        step(0, 0, 1'b0, 1'b1, 1'b1);
        total++; if (frame_count !== 8'd1) begin bad++; $display("FAIL frame2_count act=%0d exp=1", frame_count); end
        total++; if (dut.offset_q !== 10'd1) begin bad++; $display("FAIL frame2_offset act=%0d exp=1", dut.offset_q); end
        step(32, 0, 1'b1, 1'b1, 1'b1);
        total++; if ({r, g, b} !== 6'b00_00_10) begin bad++; $display("FAIL pix_32_0 act=%b exp=%b", {r, g, b}, 6'b00_00_10); end
        step(4, 4, 1'b1, 1'b1, 1'b1);
        total++; if ({r, g, b} !== 6'b01_01_00) begin bad++; $display("FAIL pix_4_4 act=%b exp=%b", {r, g, b}, 6'b01_01_00); end
        step(4, 4, 1'b0, 1'b1, 1'b1);
        total++; if ({r, g, b} !== 6'b0) begin bad++; $display("FAIL blank_rgb act=%b exp=%b", {r, g, b}, 6'b0); end
    endtask

    task automatic test_speed8();
        do_reset();
        mode = 8'h0C;
        for (int n = 1; n <= 256; n++) begin
            new_frame();
            if (n <= 130) begin
                total++;
                if (dut.offset_q !== 10'((8 * n) % 1024)) begin
                    bad++; $display("FAIL speed8_offset n=%0d act=%0d exp=%0d", n, dut.offset_q, (8 * n) % 1024);
                end
            end
            if (n == 128) begin
                total++; if (dut.offset_q !== 10'd0) begin bad++; $display("FAIL speed8_wrap act=%0d exp=0", dut.offset_q); end
            end
            if (n == 255) begin
                total++; if (frame_count !== 8'd255) begin bad++; $display("FAIL frame_255 act=%0d exp=255", frame_count); end
            end
        end
        total++; if (frame_count !== 8'd0) begin bad++; $display("FAIL frame_wrap act=%0d exp=0", frame_count); end
    endtask

    task automatic test_pause();
        do_reset();
        mode = 8'h00;
        new_frame();
        mode = 8'h10;
        step(3, 3, 1'b0, 1'b1, 1'b1);
        total++; if ({dut.offset_q, frame_count} !== {10'd1, 8'd1}) begin bad++; $display("FAIL pause_midframe act=%0d/%0d exp=1/1", dut.offset_q, frame_count); end
        new_frame();
        total++; if ({dut.offset_q, frame_count} !== {10'd1, 8'd2}) begin bad++; $display("FAIL pause_tick1 act=%0d/%0d exp=1/2", dut.offset_q, frame_count); end
        new_frame();
        total++; if ({dut.offset_q, frame_count} !== {10'd1, 8'd3}) begin bad++; $display("FAIL pause_tick2 act=%0d/%0d exp=1/3", dut.offset_q, frame_count); end
        mode = 8'h00;
        step(0, 3, 1'b0, 1'b1, 1'b1);
        total++; if (dut.offset_q !== 10'd1) begin bad++; $display("FAIL unpause_midframe act=%0d exp=1", dut.offset_q); end
        new_frame();
        total++; if ({dut.offset_q, frame_count} !== {10'd2, 8'd4}) begin bad++; $display("FAIL resume1 act=%0d/%0d exp=2/4", dut.offset_q, frame_count); end
        new_frame();
        total++; if ({dut.offset_q, frame_count} !== {10'd3, 8'd5}) begin bad++; $display("FAIL resume2 act=%0d/%0d exp=3/5", dut.offset_q, frame_count); end
    endtask

    task automatic test_direction();
        do_reset();
        mode = 8'h00;
        repeat (4) new_frame();
        mode = 8'h01;
        new_frame();
        total++; if (dut.offset_q !== 10'd5) begin bad++; $display("FAIL dir_offset act=%0d exp=5", dut.offset_q); end
        step(10, 0, 1'b1, 1'b1, 1'b1);
        total++; if ({r, g, b} !== 6'b00_00_00) begin bad++; $display("FAIL dir01_x10 act=%b exp=%b", {r, g, b}, 6'b00_00_00); end
        step(0, 0, 1'b1, 1'b1, 1'b1);
        total++; if ({r, g, b} !== 6'b10_10_10) begin bad++; $display("FAIL dir01_underflow act=%b exp=%b", {r, g, b}, 6'b10_10_10); end
        mode = 8'h10;
        new_frame();
        step(10, 0, 1'b1, 1'b1, 1'b1);
        total++; if ({r, g, b} !== 6'b10_00_00) begin bad++; $display("FAIL dir00_x10 act=%b exp=%b", {r, g, b}, 6'b10_00_00); end
        mode = 8'h12;
        new_frame();
        step(4, 3, 1'b1, 1'b1, 1'b1);
        total++; if ({r, g, b} !== 6'b11_01_00) begin bad++; $display("FAIL dir10 act=%b exp=%b", {r, g, b}, 6'b11_01_00); end
        mode = 8'h13;
        new_frame();
        step(36, 2, 1'b1, 1'b1, 1'b1);
        total++; if ({r, g, b} !== 6'b11_11_11) begin bad++; $display("FAIL dir11 act=%b exp=%b", {r, g, b}, 6'b11_11_11); end
        mode = 8'h50;
        new_frame();
        step(10, 0, 1'b1, 1'b1, 1'b1);
        total++; if ({r, g, b} !== 6'b00_00_00) begin bad++; $display("FAIL scale1_x10 act=%b exp=%b", {r, g, b}, 6'b00_00_00); end
        step(11, 0, 1'b1, 1'b1, 1'b1);
        total++; if ({r, g, b} !== 6'b10_00_00) begin bad++; $display("FAIL scale1_x11 act=%b exp=%b", {r, g, b}, 6'b10_00_00); end
        total++; if (dut.offset_q !== 10'd5) begin bad++; $display("FAIL dir_offset_held act=%0d exp=5", dut.offset_q); end
    endtask

    task automatic test_invert();
        do_reset();
        mode = 8'h20;
        new_frame();
        step(0, 0, 1'b1, 1'b0, 1'b1);
        total++; if ({r, g, b} !== 6'b11_11_11) begin bad++; $display("FAIL inv_zero act=%b exp=%b", {r, g, b}, 6'b11_11_11); end
        total++; if ({hsync_out, vsync_out} !== 2'b01) begin bad++; $display("FAIL inv_sync_a act=%b exp=%b", {hsync_out, vsync_out}, 2'b01); end
        step(0, 0, 1'b0, 1'b1, 1'b0);
        total++; if ({r, g, b} !== 6'b0) begin bad++; $display("FAIL inv_blank act=%b exp=%b", {r, g, b}, 6'b0); end
        total++; if ({hsync_out, vsync_out} !== 2'b10) begin bad++; $display("FAIL inv_sync_b act=%b exp=%b", {hsync_out, vsync_out}, 2'b10); end
        step(4, 4, 1'b1, 1'b0, 1'b0);
        total++; if ({r, g, b} !== 6'b10_10_11) begin bad++; $display("FAIL inv_4_4 act=%b exp=%b", {r, g, b}, 6'b10_10_11); end
        total++; if ({hsync_out, vsync_out} !== 2'b00) begin bad++; $display("FAIL inv_sync_c act=%b exp=%b", {hsync_out, vsync_out}, 2'b00); end
    endtask

    task automatic test_reset_on_tick();
        do_reset();
        mode = 8'h04;
        repeat (2) new_frame();
        total++; if ({dut.offset_q, frame_count} !== {10'd4, 8'd2}) begin bad++; $display("FAIL pre_rst act=%0d/%0d exp=4/2", dut.offset_q, frame_count); end
        step(0, 1, 1'b0, 1'b1, 1'b1);
        rst_n = 1'b0;
        step(0, 0, 1'b1, 1'b1, 1'b1);
        rst_n = 1'b1;
        total++; if ({dut.offset_q, frame_count, dut.mode_q, dut.prev_vpos_q} !== {10'd0, 8'd0, 8'd0, 10'd0}) begin
            bad++; $display("FAIL rst_tick act=%0d/%0d/%h/%0d exp=0/0/00/0", dut.offset_q, frame_count, dut.mode_q, dut.prev_vpos_q);
        end
        step(0, 0, 1'b0, 1'b1, 1'b1);
        total++; if (frame_count !== 8'd0) begin bad++; $display("FAIL rst_no_tick act=%0d exp=0", frame_count); end
        step(0, 2, 1'b0, 1'b1, 1'b1);
        step(0, 0, 1'b0, 1'b1, 1'b1);
        total++; if ({dut.offset_q, frame_count} !== {10'd2, 8'd1}) begin bad++; $display("FAIL rst_next_tick act=%0d/%0d exp=2/1", dut.offset_q, frame_count); end
    endtask

    initial begin
        test_reset();
        test_two_frames();
        test_speed8();
        test_pause();
        test_direction();
        test_invert();
        test_reset_on_tick();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
